hamming_decoder: RTL and testbench
==================================

Name: hamming_decoder

Overview:
- Receive-side counterpart of the Hamming(11,7) encoder.
- Takes 11-bit codewords off the channel, computes the syndrome, corrects any single-bit error, and delivers the 7 data bits downstream over a valid/ready interface.
- Two-stage pipeline with backpressure, plus saturating counters of corrected and uncorrectable words for status readout.

Parameters:
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  in_code holds a codeword.
- in_ready  out  1  decoder accepts in_code this cycle.
- in_code  in  [11:1]  codeword.
  - Data bits at positions 3,5,6,7,9,10,11 map to x1..x7.
  - Parity bits at positions 1,2,4,8.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  [7:1]  decoded/corrected data.
- out_syndrome  out  [3:0]  syndrome of the word.
- out_corr  out  1  single-bit error corrected (syndrome 1..11).
- out_uncorr  out  1  syndrome 12..15, data passed uncorrected.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  [CNT_W-1:0]  corrected-word count.
- uncorr_cnt  out  [CNT_W-1:0]  uncorrectable-word count.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low.
  - All valid flags, out_data, out_syndrome, out_corr, out_uncorr and both counters = 0.
  - in_ready = 1 from the first clock after deassertion.
- Syndrome: s = XOR of the position indices of all set bits.
  - s[0] = c1^c3^c5^c7^c9^c11.
  - s[1] = c2^c3^c6^c7^c10^c11.
  - s[2] = c4^c5^c6^c7.
  - s[3] = c8^c9^c10^c11.
- Stage 1 (S1): on in_valid && in_ready, register the code and the computed syndrome; set s1_valid.
- Stage 2 (S2/output) correction, by syndrome value:
  - s=0: clean word, both flags low.
  - s in 1..11: flip code bit s, then extract data; out_corr=1. If s is a parity position (1,2,4,8), the data is unchanged but out_corr is still 1.
  - s in 12..15: no flip; out_uncorr=1.
- Data extraction: out_data = {c11,c10,c9,c7,c6,c5,c3}.
- Handshake: standard valid/ready per stage.
  - S2 loads when !out_valid || out_ready.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || S2 loads; combinational from out_ready, no other combinational in-to-out paths.
- Outputs remain stable while out_valid && !out_ready.
- Throughput and latency:
  - One word per cycle when out_ready is held high.
  - Latency is 2 cycles from acceptance to out_valid.
  - No word is dropped or duplicated under any backpressure pattern.
- Counters:
  - corr_cnt increments on an out_valid && out_ready transfer with out_corr; uncorr_cnt likewise with out_uncorr.
  - Both saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment: result is 0.
- Multi-bit errors: double errors that alias to syndrome 1..11 are miscorrected and flagged as out_corr. This is an inherent SEC limit, not a defect.
- Reset mid-operation: in-flight words are discarded. After reset, no stale out_valid appears.

Decomposition:
- Shared package hamming_pkg holds:
  - CODE_W=11, DATA_W=7.
  - The parity-position constants (1,2,4,8).
  - The data-position list (3,5,6,7,9,10,11).
  - A syndrome typedef of 4 bits.
  - The encoder then reuses the same constants.
- One natural sub-module: hamming_syndrome, purely combinational: code[11:1] -> syndrome[3:0]. It is also usable for encoder self-check.

Test Plan:
- Clean word: in_code=11'h51C (data 7'h53), out_ready=1 -> 2 cycles later out_data=7'h53, out_syndrome=0, flags 0, counters unchanged.
- Single data-bit error: in_code=11'h53C (bit 6 flipped) -> out_data=7'h53, out_syndrome=6, out_corr=1, corr_cnt=1.
- Parity-bit error and uncorrectable: in_code=11'h51D (bit 1 flipped) -> out_data=7'h53, syndrome=1, out_corr=1. Then in_code=11'h594 (bits 4,8 flipped) -> syndrome=12, out_uncorr=1, out_data=7'h53, uncorr_cnt=1.
- Backpressure: stream 8 distinct clean codewords with out_ready toggling pseudo-randomly.
  - All 8 emerge in order, exactly once.
  - Outputs stable while stalled.
  - in_ready low only when both stages are full and out_ready=0.
- Counter saturation/clear: with CNT_W=2, send 5 single-error words -> corr_cnt=3. Assert cnt_clr in the same cycle as a corrected transfer -> corr_cnt=0.
- Async reset mid-stream: assert rst_n low between clock edges with both stages full -> out_valid and counters drop to 0 immediately. After release, the first new word emerges with 2-cycle latency.

Source files
------------

// File: rtl/hamming_pkg.sv
// hamming_pkg: constants, types and helpers shared by the Hamming(11,7)
// encoder/decoder family.
//   CODE_W / DATA_W : codeword and payload widths
//   PARITY_POS      : codeword positions holding parity (powers of two)
//   DATA_POS        : codeword positions holding x1..x7, in order
//   syndrome_t      : 4-bit syndrome
//   extract_data    : pull x7..x1 out of a codeword
//   correct_code    : flip the bit addressed by a syndrome in 1..CODE_W
package hamming_pkg;

    localparam int CODE_W     = 11;
    localparam int DATA_W     = 7;
    localparam int NUM_PARITY = 4;

    localparam int PARITY_POS [NUM_PARITY] = '{1, 2, 4, 8};
    localparam int DATA_POS   [DATA_W]     = '{3, 5, 6, 7, 9, 10, 11};

    typedef logic [3:0]        syndrome_t;
    typedef logic [CODE_W:1]   code_t;
    typedef logic [DATA_W:1]   data_t;

    // x1 is the lowest data position, x7 the highest.
    function automatic data_t extract_data(input code_t code);
        data_t d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i + 1] = code[DATA_POS[i]];
        end
        return d;
    endfunction

    // Syndromes above CODE_W address no bit and leave the word untouched.
    function automatic code_t correct_code(input code_t code, input syndrome_t syn);
        code_t r;
        r = code;
        for (int p = 1; p <= CODE_W; p++) begin
            if (syn == p[3:0]) begin
                r[p] = ~r[p];
            end
        end
        return r;
    endfunction

    function automatic logic is_correctable(input syndrome_t syn);
        return (syn != 4'd0) && (syn <= 4'd11);
    endfunction

    function automatic logic is_uncorrectable(input syndrome_t syn);
        return (syn >= 4'd12);
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: purely combinational syndrome of an 11-bit codeword.
//   code     : codeword, positions 11..1
//   syndrome : XOR of the indices of all set bits
// Bit b of the syndrome covers every position whose index has parity
// position PARITY_POS[b] set, i.e. s[0]=c1^c3^c5^c7^c9^c11 and so on.
import hamming_pkg::*;

module hamming_syndrome (
    input  logic [CODE_W:1] code,
    output logic [3:0]      syndrome
);

    // Parity check for each syndrome bit over its covered positions.
    always_comb begin
        syndrome = 4'd0;
        for (int b = 0; b < NUM_PARITY; b++) begin
            for (int p = 1; p <= CODE_W; p++) begin
                if ((p & PARITY_POS[b]) != 0) begin
                    syndrome[b] = syndrome[b] ^ code[p];
                end
            end
        end
    end

endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage Hamming(11,7) SEC decoder with valid/ready
// handshakes on both sides and saturating error counters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_code = codeword[11:1]
//   out_valid/out_ready   : downstream handshake
//   out_data              : corrected data {c11,c10,c9,c7,c6,c5,c3}
//   out_syndrome          : syndrome of the received word
//   out_corr / out_uncorr : syndrome 1..11 (flipped) / 12..15 (passed as is)
//   cnt_clr               : synchronous clear of both counters
//   corr_cnt / uncorr_cnt : saturating counts of transferred flagged words
import hamming_pkg::*;

module hamming_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:1]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:1]       out_data,
    output logic [3:0]       out_syndrome,
    output logic             out_corr,
    output logic             out_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic        ready_en_r;
    logic        s1_valid_r;
    logic [11:1] s1_code_r;
    logic [3:0]  s1_syn_r;
    logic [3:0]  in_syn_s;
    logic        s2_load_s;
    logic        in_accept_s;
    logic        xfer_s;
    logic [11:1] fixed_code_s;
    logic        fix_corr_s;
    logic        fix_uncorr_s;

    hamming_syndrome u_syndrome (
        .code     (in_code),
        .syndrome (in_syn_s)
    );

    // Handshake glue; out_ready -> in_ready is the only combinational path.
    always_comb begin
        s2_load_s   = !out_valid || out_ready;
        in_ready    = ready_en_r && (!s1_valid_r || s2_load_s);
        in_accept_s = in_valid && in_ready;
        xfer_s      = out_valid && out_ready;
    end

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Stage 1: capture codeword and its syndrome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= 11'd0;
            s1_syn_r   <= 4'd0;
        end else if (in_accept_s) begin
            // Acceptance while S2 is blocked implies S1 was empty.
            s1_valid_r <= 1'b1;
            s1_code_r  <= in_code;
            s1_syn_r   <= in_syn_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Correction of the stage-1 word ahead of the output register.
    always_comb begin
        fixed_code_s = correct_code(s1_code_r, s1_syn_r);
        fix_corr_s   = is_correctable(s1_syn_r);
        fix_uncorr_s = is_uncorrectable(s1_syn_r);
    end

    // Stage 2 / output register; frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= 7'd0;
            out_syndrome <= 4'd0;
            out_corr     <= 1'b0;
            out_uncorr   <= 1'b0;
        end else if (s2_load_s && s1_valid_r) begin
            out_valid    <= 1'b1;
            out_data     <= extract_data(fixed_code_s);
            out_syndrome <= s1_syn_r;
            out_corr     <= fix_corr_s;
            out_uncorr   <= fix_uncorr_s;
        end else if (s2_load_s) begin
            out_valid    <= 1'b0;
        end else begin
            out_valid    <= out_valid;
        end
    end

    // Corrected-word counter: clear wins, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt <= '0;
        end else if (xfer_s && out_corr && (corr_cnt != {CNT_W{1'b1}})) begin
            corr_cnt <= corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            corr_cnt <= corr_cnt;
        end
    end

    // Uncorrectable-word counter: clear wins, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            uncorr_cnt <= '0;
        end else if (xfer_s && out_uncorr && (uncorr_cnt != {CNT_W{1'b1}})) begin
            uncorr_cnt <= uncorr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            uncorr_cnt <= uncorr_cnt;
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: scoreboard bench for hamming_decoder (CNT_W = 2 so
// that counter saturation is reachable quickly).
module tb_hamming_decoder;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [11:1]      in_code;
    logic             out_valid;
    logic             out_ready;
    logic [7:1]       out_data;
    logic [3:0]       out_syndrome;
    logic             out_corr;
    logic             out_uncorr;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    hamming_decoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_corr     (out_corr),
        .out_uncorr   (out_uncorr),
        .cnt_clr      (cnt_clr),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:1] data;
        logic [3:0] syn;
        logic       corr;
        logic       uncorr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   corr_m   = 0;
    int   uncorr_m = 0;
    logic bp_on    = 1'b0;

    logic       stalled_p = 1'b0;
    logic [7:1] p_data;
    logic [3:0] p_syn;
    logic       p_corr;
    logic       p_uncorr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_syn(input logic [11:1] c);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 1; i <= 11; i++) begin
            if (c[i]) s = s ^ i[3:0];
        end
        return s;
    endfunction

    function automatic exp_t model(input logic [11:1] c);
        exp_t       e;
        logic [3:0] s;
        logic [11:1] fc;
        s        = model_syn(c);
        fc       = c;
        e.syn    = s;
        e.corr   = (s >= 4'd1) && (s <= 4'd11);
        e.uncorr = (s >= 4'd12);
        if (e.corr) fc[s] = ~fc[s];
        e.data   = {fc[11], fc[10], fc[9], fc[7], fc[6], fc[5], fc[3]};
        return e;
    endfunction

    function automatic logic [11:1] encode(input logic [7:1] d);
        logic [11:1] c;
        logic [3:0]  s;
        c     = 11'd0;
        c[3]  = d[1]; c[5]  = d[2]; c[6]  = d[3]; c[7] = d[4];
        c[9]  = d[5]; c[10] = d[6]; c[11] = d[7];
        s     = model_syn(c);
        c[1]  = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
        return c;
    endfunction

    // Monitor: counters, in_ready rule, stall stability, scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            corr_m    = 0;
            uncorr_m  = 0;
            stalled_p = 1'b0;
        end else begin
            check("corr_cnt", corr_cnt, corr_m);
            check("uncorr_cnt", uncorr_cnt, uncorr_m);
            check("in_ready", in_ready, !((sb.size() == 2) && !out_ready));
            if (stalled_p) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, p_data);
                check("stall_syn", out_syndrome, p_syn);
                check("stall_corr", out_corr, p_corr);
                check("stall_uncorr", out_uncorr, p_uncorr);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_data", out_data, mon_e.data);
                    check("sb_syn", out_syndrome, mon_e.syn);
                    check("sb_corr", out_corr, mon_e.corr);
                    check("sb_uncorr", out_uncorr, mon_e.uncorr);
                    if (!cnt_clr && mon_e.corr && corr_m < CNT_MAX) corr_m++;
                    if (!cnt_clr && mon_e.uncorr && uncorr_m < CNT_MAX) uncorr_m++;
                end
            end
            if (cnt_clr) begin
                corr_m   = 0;
                uncorr_m = 0;
            end
            if (in_valid && in_ready) sb.push_back(model(in_code));
            stalled_p = out_valid && !out_ready;
            p_data    = out_data;
            p_syn     = out_syndrome;
            p_corr    = out_corr;
            p_uncorr  = out_uncorr;
        end
    end

    // One isolated word with out_ready high; checks 2-cycle latency and output.
    task automatic send_single(input logic [11:1] code, input logic [7:1] d,
                               input logic [3:0] s, input logic c, input logic u,
                               input logic clr);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_code  = code;
        @(negedge clk);
        check("single_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_early", out_valid, 1'b0);
        @(posedge clk); #1;
        cnt_clr = clr;
        @(negedge clk);
        check("latency_valid", out_valid, 1'b1);
        check("single_data", out_data, d);
        check("single_syn", out_syndrome, s);
        check("single_corr", out_corr, c);
        check("single_uncorr", out_uncorr, u);
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    // Present a word and hold it until the DUT accepts it (bounded).
    task automatic drive_word(input logic [11:1] code);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_code  = code;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("bp_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [11:1] c;
        int          w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 11'd0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 7'd0);
        check("rst_out_syn", out_syndrome, 4'd0);
        check("rst_out_corr", out_corr, 1'b0);
        check("rst_out_uncorr", out_uncorr, 1'b0);
        check("rst_corr_cnt", corr_cnt, 2'd0);
        check("rst_uncorr_cnt", uncorr_cnt, 2'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1'b1);

        // Clean, data-bit error, parity-bit error, uncorrectable.
        send_single(11'h51C, 7'h53, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_corr_cnt", corr_cnt, 2'd0);
        send_single(11'h53C, 7'h53, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_corr_cnt", corr_cnt, 2'd1);
        send_single(11'h51D, 7'h53, 4'd1, 1'b1, 1'b0, 1'b0);
        send_single(11'h594, 7'h53, 4'd12, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_uncorr_cnt", uncorr_cnt, 2'd1);
        check("t3_corr_cnt", corr_cnt, 2'd2);

        // Backpressure stream of 8 distinct clean words.
        @(posedge clk); #1;
        bp_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    drive_word(encode(7'(i * 13 + 5)));
                end
                w = 0;
                while (sb.size() != 0 && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                check("bp_drain", sb.size(), 0);
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;

        // Saturation with five single-error words, then clear vs increment.
        for (int i = 0; i < 5; i++) begin
            c = encode(7'(i * 21 + 3));
            c[i + 3] = ~c[i + 3];
            send_single(c, 7'(i * 21 + 3), 4'(i + 3), 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("sat_corr_cnt", corr_cnt, 2'd3);
        send_single(11'h53C, 7'h53, 4'd6, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("clr_corr_cnt", corr_cnt, 2'd0);
        send_single(11'h53C, 7'h53, 4'd6, 1'b1, 1'b0, 1'b0);
        send_single(11'h594, 7'h53, 4'd12, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_corr", corr_cnt, 2'd1);
        check("pre_rst_uncorr", uncorr_cnt, 2'd1);

        // Fill both stages under backpressure, then reset asynchronously.
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_code  = 11'h53C;
        @(posedge clk); #1;
        in_code  = 11'h51D;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_valid", out_valid, 1'b1);
        check("full_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_corr_cnt", corr_cnt, 2'd0);
        check("arst_uncorr_cnt", uncorr_cnt, 2'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_no_stale", out_valid, 1'b0);
        send_single(11'h51C, 7'h53, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("final_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
